// File: rtl/led_chase_sched_if.sv
// Purpose : bundles the run-control inputs and the LED bank / status outputs of the LED-chase sequencer.
// Latency : n/a (signal bundle only).
// Backpressure: none; en is a level, and every output is a registered strobe or level.
//
// Ports (modport view):
//   master : drives en, mode; observes led, busy, tick, done (board switches / test driver side)
//   slave  : sees en, mode; drives led, busy, tick, done (the sequencer itself)
interface led_chase_sched_if #(
    parameter int N_LED = 8
) ();
    logic             en;
    logic [1:0]       mode;
    logic [N_LED-1:0] led;
    logic             busy;
    logic             tick;
    logic             done;

    modport master (
        output en,
        output mode,
        input  led,
        input  busy,
        input  tick,
        input  done
    );

    modport slave (
        input  en,
        input  mode,
        output led,
        output busy,
        output tick,
        output done
    );
endinterface

// File: rtl/led_chase_sched.sv
// Purpose : LED-chase demo sequencer; steps a chase pattern every TICK_DIV clocks for PASSES passes.
// Latency : first pattern appears on the cycle after en is seen high in IDLE; done pulses in the first IDLE cycle.
// Backpressure: none; en low during a run aborts on the next cycle, with no done pulse.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   io     led_chase_sched_if.slave : en (level), mode (0=L2R,1=R2L,2=PING-PONG,3=BLINK, sampled at start),
//          led (active-high bank, led[N_LED-1] leftmost), busy (high in RUN), tick (step strobe), done (pulse)
// Build option:
//   LED_FILL_EN defined  -> L2R / R2L / PING-PONG fill the bank like a bar graph instead of moving a single dot.
//   LED_FILL_EN undefined -> single-dot chase.
module led_chase_sched #(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 25000000,
    parameter int PASSES   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    led_chase_sched_if.slave   io
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(N_LED);
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [CW-1:0]    CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [SW-1:0]    STEP_LAST = SW'(N_LED - 1);
    localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
    localparam logic [N_LED-1:0] LED_MSB   = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] LED_LSB   = N_LED'(1);
    localparam logic [N_LED-1:0] LED_ONES  = '1;

    localparam logic [1:0] M_R2L   = 2'd1;
    localparam logic [1:0] M_PP    = 2'd2;
    localparam logic [1:0] M_BLINK = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    step;
    logic [PW-1:0]    pass;
    logic [1:0]       mode_q;
    logic             r2l_q;    // current chase direction; only ever flips in PING-PONG
    logic [N_LED-1:0] led_q;
    logic             busy_q;
    logic             tick_q;
    logic             done_q;

    // Pattern shown at the start of every pass.
    function automatic logic [N_LED-1:0] first_pat(input logic [1:0] md, input logic r2l);
        if (md == M_BLINK) begin
            return LED_ONES;
        end
        return r2l ? LED_LSB : LED_MSB;
    endfunction

    // Pattern for the following step within a pass.
    function automatic logic [N_LED-1:0] next_pat(input logic [N_LED-1:0] cur,
                                                  input logic [1:0]       md,
                                                  input logic             r2l);
        if (md == M_BLINK) begin
            return ~cur;
        end
`ifdef LED_FILL_EN
        return r2l ? ((cur << 1) | LED_LSB) : ((cur >> 1) | LED_MSB);
`else
        return r2l ? (cur << 1) : (cur >> 1);
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            step   <= '0;
            pass   <= '0;
            mode_q <= '0;
            r2l_q  <= 1'b0;
            led_q  <= '0;
            busy_q <= 1'b0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    led_q  <= '0;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    tick_q <= 1'b0;
                    done_q <= 1'b0;
                    if (io.en) begin
                        state  <= RUN;
                        mode_q <= io.mode;
                        r2l_q  <= (io.mode == M_R2L);
                        step   <= '0;
                        pass   <= '0;
                        led_q  <= first_pat(io.mode, io.mode == M_R2L);
                        busy_q <= 1'b1;
                        // tick is registered, so it is set one cycle early: high while cnt==TICK_DIV-1
                        tick_q <= (CNT_LAST == '0);
                    end
                end

                RUN: begin
                    done_q <= 1'b0;
                    if (!io.en) begin
                        // abort takes priority over any tick or pass end this cycle
                        state  <= IDLE;
                        led_q  <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        tick_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        tick_q <= (CNT_LAST == '0);
                        if (step == STEP_LAST) begin
                            if (pass == PASS_LAST) begin
                                state  <= IDLE;
                                led_q  <= '0;
                                busy_q <= 1'b0;
                                tick_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                pass <= pass + 1'b1;
                                step <= '0;
                                if (mode_q == M_PP) begin
                                    // reload from the new direction's end LED, so it is shown twice in a row
                                    r2l_q <= ~r2l_q;
                                    led_q <= first_pat(mode_q, ~r2l_q);
                                end else begin
                                    led_q <= first_pat(mode_q, r2l_q);
                                end
                            end
                        end else begin
                            step  <= step + 1'b1;
                            led_q <= next_pat(led_q, mode_q, r2l_q);
                        end
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                        tick_q <= ((cnt + CNT_ONE) == CNT_LAST);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io.led  = led_q;
    assign io.busy = busy_q;
    assign io.tick = tick_q;
    assign io.done = done_q;

endmodule

// File: tb/tb_led_chase_sched.sv
// Purpose : checks led_chase_sched (N_LED=4, PASSES=2) at TICK_DIV=4 and TICK_DIV=1 against a time-indexed model.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_led_chase_sched;
    localparam int N = 4;
    localparam int P = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_d;
    logic [1:0] mode_d;

    always #5 clk = ~clk;

    led_chase_sched_if #(.N_LED(N)) if4 ();
    led_chase_sched_if #(.N_LED(N)) if1 ();

    assign if4.en   = en_d;
    assign if4.mode = mode_d;
    assign if1.en   = en_d;
    assign if1.mode = mode_d;

    led_chase_sched #(.N_LED(N), .TICK_DIV(4), .PASSES(P)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if4.slave)
    );

    led_chase_sched #(.N_LED(N), .TICK_DIV(1), .PASSES(P)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if1.slave)
    );

    // Model state: running flag, busy cycles elapsed in this run, latched mode, pending done.
    typedef struct {
        bit run;
        int k;
        int md;
        bit done;
    } mdl_t;

    mdl_t m4;
    mdl_t m1;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected LED bank for a given pass and step, straight from the pattern rules.
    function automatic int exp_led(input int md, input int ps, input int st);
        bit r2l;
        int ones;
        if (md == 3) begin
            return (st % 2 == 0) ? ((1 << N) - 1) : 0;
        end
        r2l  = (md == 1) || (md == 2 && (ps % 2) == 1);
        ones = (1 << (st + 1)) - 1;
`ifdef LED_FILL_EN
        return r2l ? ones : (ones << (N - 1 - st));
`else
        if (ones == 0) return 0;
        return r2l ? (1 << st) : (1 << (N - 1 - st));
`endif
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input bit r, input bit e, input int md, input int td);
        mdl_t nx;
        nx = m;
        if (!r) begin
            nx.run = 0; nx.k = 0; nx.done = 0;
        end else if (!m.run) begin
            nx.done = 0;
            if (e) begin
                nx.run = 1; nx.k = 0; nx.md = md;
            end
        end else if (!e) begin
            nx.run = 0; nx.done = 0;
        end else if (m.k == N * P * td - 1) begin
            nx.run = 0; nx.done = 1;
        end else begin
            nx.k = m.k + 1;
        end
        return nx;
    endfunction

    task automatic check_dut(input string pfx, input mdl_t m, input int td,
                             input logic [N-1:0] led, input logic busy, input logic tick, input logic done);
        int idx;
        int e_led;
        idx   = m.k / td;
        e_led = m.run ? exp_led(m.md, idx / N, idx % N) : 0;
        chk({pfx, "_led"},  32'(led),  e_led);
        chk({pfx, "_busy"}, 32'(busy), 32'(m.run));
        chk({pfx, "_tick"}, 32'(tick), 32'(m.run && (m.k % td == td - 1)));
        chk({pfx, "_done"}, 32'(done), 32'(m.done));
    endtask

    // One clock: inputs already set, advance the model on the edge, compare just after it.
    task automatic cycle();
        @(posedge clk);
        m4 = mdl_next(m4, rst_n, en_d, int'(mode_d), 4);
        m1 = mdl_next(m1, rst_n, en_d, int'(mode_d), 1);
        #1;
        check_dut("d4", m4, 4, if4.led, if4.busy, if4.tick, if4.done);
        check_dut("d1", m1, 1, if1.led, if1.busy, if1.tick, if1.done);
    endtask

    // Pattern at the start of each of the 8 steps of a run, written out literally.
    function automatic int tbl(input int md, input int j);
        int t[8];
        case (md)
`ifdef LED_FILL_EN
            0: t = '{8, 12, 14, 15, 8, 12, 14, 15};
            1: t = '{1, 3, 7, 15, 1, 3, 7, 15};
            2: t = '{8, 12, 14, 15, 1, 3, 7, 15};
`else
            0: t = '{8, 4, 2, 1, 8, 4, 2, 1};
            1: t = '{1, 2, 4, 8, 1, 2, 4, 8};
            2: t = '{8, 4, 2, 1, 1, 2, 4, 8};
`endif
            default: t = '{15, 0, 15, 0, 15, 0, 15, 0};
        endcase
        return t[j];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        en_d  = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic scen_mode(input int md);
        int busy_n;
        int done_n;
        string nm;
        busy_n = 0;
        done_n = 0;
        nm = $sformatf("m%0d", md);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            en_d   = (i < 33);
            mode_d = 2'(md);
            cycle();
            if (if4.busy) busy_n++;
            if (if4.done) begin
                done_n++;
                chk({nm, "_done_led"}, 32'(if4.led), 0);
            end
            if (i < 32 && i % 4 == 0) chk($sformatf("%s_pat%0d", nm, i / 4), 32'(if4.led), tbl(md, i / 4));
        end
        chk({nm, "_busy_cycles"}, busy_n, 32);
        chk({nm, "_done_pulses"}, done_n, 1);
    endtask

    initial begin
        m4 = '{0, 0, 0, 0};
        m1 = '{0, 0, 0, 0};

        // reset held two cycles with en high
        rst_n  = 1'b0;
        en_d   = 1'b1;
        mode_d = 2'd0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_led",  32'(if4.led),  0);
            chk("rst_busy", 32'(if4.busy), 0);
            chk("rst_tick", 32'(if4.tick), 0);
            chk("rst_done", 32'(if4.done), 0);
        end
        rst_n = 1'b1;
        en_d  = 1'b0;
        cycle();

        for (int md = 0; md < 4; md++) scen_mode(md);

        // abort on the tick cycle of pass 1, step 2
        do_reset();
        en_d   = 1'b1;
        mode_d = 2'd0;
        for (int i = 0; i < 28; i++) cycle();
        chk("abort_tick_seen", 32'(if4.tick), 1);
        en_d = 1'b0;
        cycle();
        chk("abort_led",  32'(if4.led),  0);
        chk("abort_busy", 32'(if4.busy), 0);
        begin
            int dn;
            dn = 0;
            for (int i = 0; i < 5; i++) begin
                cycle();
                if (if4.done) dn++;
            end
            chk("abort_no_done", dn, 0);
        end
        en_d = 1'b1;
        cycle();
        chk("abort_restart_led", 32'(if4.led), tbl(0, 0));

        // TICK_DIV=1: mode switched mid-run must not disturb the R2L chase
        do_reset();
        for (int i = 0; i < 12; i++) begin
            en_d   = (i < 9);
            mode_d = (i < 3) ? 2'd1 : 2'd0;
            cycle();
            if (i < 8) chk($sformatf("td1_pat%0d", i), 32'(if1.led), tbl(1, i));
            if (i == 8) begin
                chk("td1_done", 32'(if1.done), 1);
                chk("td1_done_led", 32'(if1.led), 0);
            end
        end

        // random en / mode / occasional reset
        for (int i = 0; i < 2500; i++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            en_d   = ($urandom_range(0, 63) != 0);
            mode_d = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
